// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : MIPS instruction-fetch stage with PC, IF/ID register, stall,
//            redirect and sticky end-of-memory halt.
// Revision : 1.0
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 32,
    parameter logic [31:0] NOP        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fetch_halt
);

    // Limit held in 33 bits so a 2^30-word memory spans the full address space.
    localparam logic [32:0] c_imem_limit = 33'(IMEM_WORDS) << 2;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic        r_halt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_tgt;
    logic        w_in_range;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_redirect_tgt = redirect_pc & ~32'h0000_0003;
    assign w_in_range     = ({1'b0, r_pc} < c_imem_limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
            r_halt       <= 1'b0;
        end else if (redirect) begin
            r_pc         <= w_redirect_tgt;
            r_ifid_instr <= NOP;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
            r_halt       <= 1'b0;
        end else if (r_halt) begin
            r_ifid_instr <= NOP;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else if (stall) begin
            r_pc <= r_pc;
        end else if (w_in_range) begin
            r_pc         <= w_pc_plus4;
            r_ifid_instr <= imem_instr;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_valid <= 1'b1;
        end else begin
            // Ran past the end of memory: park the PC and stop fetching.
            r_ifid_instr <= NOP;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
            r_halt       <= 1'b1;
        end
    end

    assign imem_addr  = r_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc4   = r_ifid_pc4;
    assign ifid_valid = r_ifid_valid;
    assign fetch_halt = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Directed self-checking bench for if_stage.
// Revision : 1.0
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr, imem_instr, ifid_instr, ifid_pc4;
    logic        ifid_valid, fetch_halt;

    logic [31:0] w_addr, w_instr, w_pc4;
    logic        w_valid, w_halt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Memory word i holds 0xA000_0000 + i; out-of-range reads return garbage.
    assign imem_instr = (imem_addr < 32'h80) ? (32'hA000_0000 + (imem_addr >> 2)) : 32'hDEAD_BEEF;

    if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(32), .NOP(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .fetch_halt(fetch_halt)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(32'h4000_0000), .NOP(32'h0)) u_wrap (
        .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_addr(w_addr), .imem_instr(32'h1234_5678),
        .ifid_instr(w_instr), .ifid_pc4(w_pc4), .ifid_valid(w_valid),
        .fetch_halt(w_halt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want %h", imem_addr, 32'h0); else n_pass++;
        n_total++; if (ifid_instr !== 32'h0) $display("FAIL rst_instr: got %h want %h", ifid_instr, 32'h0); else n_pass++;
        n_total++; if (ifid_pc4 !== 32'h0) $display("FAIL rst_pc4: got %h want %h", ifid_pc4, 32'h0); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", ifid_valid); else n_pass++;
        n_total++; if (fetch_halt !== 1'b0) $display("FAIL rst_halt: got %b want 0", fetch_halt); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_instr, exp_pc4;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_instr = 32'hA000_0000 + 32'(i);
            exp_pc4   = 32'(4 * (i + 1));
            n_total++; if (ifid_instr !== exp_instr) $display("FAIL seq_instr%0d: got %h want %h", i, ifid_instr, exp_instr); else n_pass++;
            n_total++; if (ifid_pc4 !== exp_pc4) $display("FAIL seq_pc4_%0d: got %h want %h", i, ifid_pc4, exp_pc4); else n_pass++;
            n_total++; if (ifid_valid !== 1'b1) $display("FAIL seq_valid%0d: got %b want 1", i, ifid_valid); else n_pass++;
        end
        n_total++; if (imem_addr !== 32'h10) $display("FAIL seq_addr: got %h want %h", imem_addr, 32'h10); else n_pass++;
    endtask

    task automatic test_stall();
        redirect = 1'b1; redirect_pc = 32'h4;
        step();
        redirect = 1'b0;
        step();
        n_total++; if (imem_addr !== 32'h8) $display("FAIL stall_pre_addr: got %h want %h", imem_addr, 32'h8); else n_pass++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (imem_addr !== 32'h8) $display("FAIL stall_addr%0d: got %h want %h", i, imem_addr, 32'h8); else n_pass++;
            n_total++; if (ifid_instr !== 32'hA000_0001) $display("FAIL stall_instr%0d: got %h want %h", i, ifid_instr, 32'hA000_0001); else n_pass++;
            n_total++; if (ifid_pc4 !== 32'h8) $display("FAIL stall_pc4_%0d: got %h want %h", i, ifid_pc4, 32'h8); else n_pass++;
        end
        stall = 1'b0;
        step();
        n_total++; if (ifid_instr !== 32'hA000_0002) $display("FAIL stall_rel_instr: got %h want %h", ifid_instr, 32'hA000_0002); else n_pass++;
        n_total++; if (imem_addr !== 32'hC) $display("FAIL stall_rel_addr: got %h want %h", imem_addr, 32'hC); else n_pass++;
    endtask

    task automatic test_redirect(input logic with_stall);
        redirect = 1'b1; redirect_pc = 32'h48;
        step();
        n_total++; if (imem_addr !== 32'h48) $display("FAIL redir_setup_addr: got %h want %h", imem_addr, 32'h48); else n_pass++;
        redirect_pc = 32'h3B; stall = with_stall;
        step();
        redirect = 1'b0; stall = 1'b0;
        n_total++; if (imem_addr !== 32'h38) $display("FAIL redir_addr(s=%0b): got %h want %h", with_stall, imem_addr, 32'h38); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL redir_bubble(s=%0b): got %b want 0", with_stall, ifid_valid); else n_pass++;
        n_total++; if (ifid_instr !== 32'h0) $display("FAIL redir_nop(s=%0b): got %h want %h", with_stall, ifid_instr, 32'h0); else n_pass++;
        step();
        n_total++; if (ifid_instr !== 32'hA000_000E) $display("FAIL redir_instr(s=%0b): got %h want %h", with_stall, ifid_instr, 32'hA000_000E); else n_pass++;
        n_total++; if (ifid_pc4 !== 32'h3C) $display("FAIL redir_pc4(s=%0b): got %h want %h", with_stall, ifid_pc4, 32'h3C); else n_pass++;
        n_total++; if (ifid_valid !== 1'b1) $display("FAIL redir_valid(s=%0b): got %b want 1", with_stall, ifid_valid); else n_pass++;
    endtask

    task automatic test_run_off_end();
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 32; i++) step();
        n_total++; if (ifid_instr !== 32'hA000_001F) $display("FAIL end_last_instr: got %h want %h", ifid_instr, 32'hA000_001F); else n_pass++;
        n_total++; if (ifid_pc4 !== 32'h80) $display("FAIL end_last_pc4: got %h want %h", ifid_pc4, 32'h80); else n_pass++;
        n_total++; if (fetch_halt !== 1'b0) $display("FAIL end_early_halt: got %b want 0", fetch_halt); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) stall = 1'b1;
            step();
            n_total++; if (fetch_halt !== 1'b1) $display("FAIL end_halt%0d: got %b want 1", i, fetch_halt); else n_pass++;
            n_total++; if (ifid_valid !== 1'b0) $display("FAIL end_valid%0d: got %b want 0", i, ifid_valid); else n_pass++;
            n_total++; if (imem_addr !== 32'h80) $display("FAIL end_addr%0d: got %h want %h", i, imem_addr, 32'h80); else n_pass++;
        end
        stall = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h7C;
        step();
        redirect = 1'b0;
        n_total++; if (fetch_halt !== 1'b0) $display("FAIL end_clear_halt: got %b want 0", fetch_halt); else n_pass++;
        n_total++; if (imem_addr !== 32'h7C) $display("FAIL end_redir_addr: got %h want %h", imem_addr, 32'h7C); else n_pass++;
        step();
        n_total++; if (ifid_instr !== 32'hA000_001F) $display("FAIL end_refetch_instr: got %h want %h", ifid_instr, 32'hA000_001F); else n_pass++;
        n_total++; if (ifid_valid !== 1'b1) $display("FAIL end_refetch_valid: got %b want 1", ifid_valid); else n_pass++;
        step();
        n_total++; if (fetch_halt !== 1'b1) $display("FAIL end_rehalt: got %b want 1", fetch_halt); else n_pass++;
    endtask

    task automatic test_async_reset();
        redirect = 1'b1; redirect_pc = 32'h20;
        step();
        redirect = 1'b0;
        step();
        n_total++; if (imem_addr !== 32'h24) $display("FAIL arst_pre_addr: got %h want %h", imem_addr, 32'h24); else n_pass++;
        n_total++; if (ifid_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b want 1", ifid_valid); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL arst_addr: got %h want %h", imem_addr, 32'h0); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", ifid_valid); else n_pass++;
        n_total++; if (ifid_instr !== 32'h0) $display("FAIL arst_instr: got %h want %h", ifid_instr, 32'h0); else n_pass++;
        n_total++; if (ifid_pc4 !== 32'h0) $display("FAIL arst_pc4: got %h want %h", ifid_pc4, 32'h0); else n_pass++;
        step();
        reset = 1'b0;
        step();
        n_total++; if (ifid_instr !== 32'hA000_0000) $display("FAIL arst_restart_instr: got %h want %h", ifid_instr, 32'hA000_0000); else n_pass++;
        n_total++; if (ifid_pc4 !== 32'h4) $display("FAIL arst_restart_pc4: got %h want %h", ifid_pc4, 32'h4); else n_pass++;
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        #2;
        n_total++; if (w_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_rst_addr: got %h want %h", w_addr, 32'hFFFF_FFFC); else n_pass++;
        step();
        reset = 1'b0;
        step();
        n_total++; if (w_pc4 !== 32'h0) $display("FAIL wrap_pc4: got %h want %h", w_pc4, 32'h0); else n_pass++;
        n_total++; if (w_addr !== 32'h0) $display("FAIL wrap_addr: got %h want %h", w_addr, 32'h0); else n_pass++;
        n_total++; if (w_halt !== 1'b0) $display("FAIL wrap_halt: got %b want 0", w_halt); else n_pass++;
        n_total++; if (w_valid !== 1'b1) $display("FAIL wrap_valid: got %b want 1", w_valid); else n_pass++;
        n_total++; if (w_instr !== 32'h1234_5678) $display("FAIL wrap_instr: got %h want %h", w_instr, 32'h1234_5678); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_run_off_end();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
